board_ownership: RTL and testbench

BOARD_OWNERSHIP -- requirements
Module: board_ownership

---
 rtl/board_ownership.sv | 185 ++++++++++++++++++
 tb/tb_board_ownership.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ownership.sv
// Drop-token board: tracks which player owns each cell, whose turn it is,
// and accepts or refuses one confirmed move per rising confirm edge.
module board_ownership #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int PLAYERS = 2,
  localparam int OW = $clog2(PLAYERS + 1),
  localparam int PW = (PLAYERS > 2) ? $clog2(PLAYERS) : 1,
  localparam int CW = $clog2(ROWS * COLS + 1),
  localparam int RW = $clog2(ROWS),
  localparam int LW = $clog2(COLS)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 new_game,
  input  logic [PLAYERS-1:0][COLS-1:0]         player_sel,
  input  logic [PLAYERS-1:0]                   player_confirm,
  output logic [ROWS-1:0][COLS-1:0][OW-1:0]    tokens,
  output logic [PW-1:0]                        current_player,
  output logic                                 move_accepted,
  output logic                                 move_rejected,
  output logic [RW-1:0]                        last_row,
  output logic [LW-1:0]                        last_col,
  output logic [CW-1:0]                        move_count,
  output logic                                 board_full
);

  localparam logic [CW-1:0] CELLS     = CW'(ROWS * COLS);
  localparam logic [PW-1:0] LAST_PLYR = PW'(PLAYERS - 1);

  typedef enum logic {PLAY, FULL} state_t;

  state_t                    state_reg, state_next;
  logic [PLAYERS-1:0]        confirm_reg;
  logic [PLAYERS-1:0]        confirm_event;
  logic [PW-1:0]             current_player_reg;
  logic [CW-1:0]             move_count_reg;
  logic [RW-1:0]             last_row_reg;
  logic [LW-1:0]             last_col_reg;
  logic                      accepted_reg;
  logic                      rejected_reg;

  logic                      act;
  logic [COLS-1:0]           sel;
  logic [COLS-1:0]           col_open;
  logic [COLS-1:0][RW-1:0]   drop_row;
  logic [LW-1:0]             sel_col;
  logic                      move_ok;
  logic                      commit;
  logic                      refuse;
  logic [PW-1:0]             player_next;

  assign confirm_event = player_confirm & ~confirm_reg;
  assign act           = confirm_event[current_player_reg];
  assign sel           = player_sel[current_player_reg];
  assign board_full    = (move_count_reg == CELLS);

  // Tokens stack from the bottom, so a column has room iff its top cell is empty.
  genvar gi, gj;
  generate
    for (gj = 0; gj < COLS; gj++) begin : g_col
      logic [RW-1:0] drop_row_c;

      assign col_open[gj] = (tokens[0][gj] == '0);

      always_comb begin
        drop_row_c = '0;
        for (int r = 0; r < ROWS; r++) begin
          if (tokens[r][gj] == '0) begin
            drop_row_c = RW'(r);
          end
        end
      end

      assign drop_row[gj] = drop_row_c;
    end
  endgenerate

  always_comb begin
    sel_col = '0;
    for (int c = 0; c < COLS; c++) begin
      if (sel[c]) begin
        sel_col = LW'(c);
      end
    end
  end

  assign move_ok     = $onehot(sel) && ((sel & col_open) != '0) && !board_full;
  assign player_next = (current_player_reg == LAST_PLYR) ? '0
                                                         : current_player_reg + PW'(1);

  // Next-state and move decision; new_game overrides any confirm at the same edge.
  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    refuse     = 1'b0;
    case (state_reg)
      PLAY: begin
        if (act) begin
          if (move_ok) begin
            commit = 1'b1;
            if (move_count_reg == CELLS - CW'(1)) begin
              state_next = FULL;
            end
          end else begin
            refuse = 1'b1;
          end
        end
      end
      FULL: begin
        if (act) begin
          refuse = 1'b1;
        end
      end
      default: state_next = PLAY;
    endcase
    if (new_game) begin
      state_next = PLAY;
      commit     = 1'b0;
      refuse     = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= PLAY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      confirm_reg        <= '0;
      current_player_reg <= '0;
      move_count_reg     <= '0;
      last_row_reg       <= '0;
      last_col_reg       <= '0;
      accepted_reg       <= 1'b0;
      rejected_reg       <= 1'b0;
    end else begin
      confirm_reg  <= player_confirm;
      accepted_reg <= commit;
      rejected_reg <= refuse;
      if (new_game) begin
        current_player_reg <= '0;
        move_count_reg     <= '0;
        last_row_reg       <= '0;
        last_col_reg       <= '0;
      end else if (commit) begin
        current_player_reg <= player_next;
        move_count_reg     <= move_count_reg + CW'(1);
        last_row_reg       <= drop_row[sel_col];
        last_col_reg       <= sel_col;
      end
    end
  end

  // One register per cell; only the landing cell of a committed move is written.
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      for (gj = 0; gj < COLS; gj++) begin : g_cell
        logic [OW-1:0] cell_reg;

        always_ff @(posedge clock) begin
          if (reset || new_game) begin
            cell_reg <= '0;
          end else if (commit && sel[gj] && (drop_row[gj] == RW'(gi))) begin
            cell_reg <= OW'(current_player_reg) + OW'(1);
          end
        end

        assign tokens[gi][gj] = cell_reg;
      end
    end
  endgenerate

  assign current_player = current_player_reg;
  assign move_accepted  = accepted_reg;
  assign move_rejected  = rejected_reg;
  assign last_row       = last_row_reg;
  assign last_col       = last_col_reg;
  assign move_count     = move_count_reg;

endmodule

// File: tb/tb_board_ownership.sv
// Bench for board_ownership: directed scenarios plus random play, checked
// against a column-height model of the board.
module tb_board_ownership;

  localparam int R  = 6;
  localparam int C  = 7;
  localparam int P  = 2;
  localparam int OW = 2;

  logic                        clock = 1'b0;
  logic                        reset;
  logic                        new_game;
  logic [P-1:0][C-1:0]         player_sel;
  logic [P-1:0]                player_confirm;
  logic [R-1:0][C-1:0][OW-1:0] tokens;
  logic [0:0]                  current_player;
  logic                        move_accepted;
  logic                        move_rejected;
  logic [2:0]                  last_row;
  logic [2:0]                  last_col;
  logic [5:0]                  move_count;
  logic                        board_full;

  // Three-player 4x4 instance
  logic                        new3;
  logic [2:0][3:0]             sel3;
  logic [2:0]                  conf3;
  logic [3:0][3:0][1:0]        tok3;
  logic [1:0]                  cur3;
  logic                        acc3, rej3;
  logic [1:0]                  lr3, lc3;
  logic [4:0]                  cnt3;
  logic                        full3;

  board_ownership dut (
    .clock(clock), .reset(reset), .new_game(new_game),
    .player_sel(player_sel), .player_confirm(player_confirm),
    .tokens(tokens), .current_player(current_player),
    .move_accepted(move_accepted), .move_rejected(move_rejected),
    .last_row(last_row), .last_col(last_col),
    .move_count(move_count), .board_full(board_full)
  );

  board_ownership #(.ROWS(4), .COLS(4), .PLAYERS(3)) dut3 (
    .clock(clock), .reset(reset), .new_game(new3),
    .player_sel(sel3), .player_confirm(conf3),
    .tokens(tok3), .current_player(cur3),
    .move_accepted(acc3), .move_rejected(rej3),
    .last_row(lr3), .last_col(lc3),
    .move_count(cnt3), .board_full(full3)
  );

  always #5 clock = ~clock;

  int pass_count  = 0;
  int check_count = 0;

  // Reference model: owners per cell plus the fill height of every column
  int m_owner [R][C];
  int m_height[C];
  int m_cur, m_cnt, m_lr, m_lc;
  bit m_acc, m_rej;
  bit [P-1:0] m_prev;

  task automatic check(input string tag, input longint got, input longint exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) m_owner[r][c] = 0;
    for (int c = 0; c < C; c++) m_height[c] = 0;
    m_cur = 0; m_cnt = 0; m_lr = 0; m_lc = 0;
  endtask

  task automatic model_step();
    bit [P-1:0] ev;
    logic [C-1:0] s;
    int col, row;
    ev = player_confirm & ~m_prev;
    m_acc = 1'b0;
    m_rej = 1'b0;
    if (reset) begin
      model_clear();
      m_prev = '0;
    end else begin
      if (new_game) begin
        model_clear();
      end else if (ev[m_cur]) begin
        s = player_sel[m_cur];
        col = 0;
        for (int c = 0; c < C; c++) if (s[c]) col = c;
        if ($countones(s) == 1 && m_cnt < R * C && m_height[col] < R) begin
          row = R - 1 - m_height[col];
          m_owner[row][col] = m_cur + 1;
          m_height[col]++;
          m_lr = row;
          m_lc = col;
          m_cnt++;
          m_cur = (m_cur + 1) % P;
          m_acc = 1'b1;
        end else begin
          m_rej = 1'b1;
        end
      end
      m_prev = player_confirm;
    end
  endtask

  task automatic compare_all();
    logic [C*OW-1:0] er;
    for (int r = 0; r < R; r++) begin
      er = '0;
      for (int c = 0; c < C; c++) er[c*OW +: OW] = OW'(m_owner[r][c]);
      check($sformatf("row%0d", r), tokens[r], er);
    end
    check("cur", current_player, m_cur);
    check("acc", move_accepted, m_acc);
    check("rej", move_rejected, m_rej);
    check("count", move_count, m_cnt);
    check("last_row", last_row, m_lr);
    check("last_col", last_col, m_lc);
    check("full", board_full, (m_cnt == R * C));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic press(input int p, input logic [C-1:0] s, output bit acc, output bit rej);
    player_sel[p]     = s;
    player_confirm[p] = 1'b1;
    tick();
    acc = move_accepted;
    rej = move_rejected;
    player_confirm[p] = 1'b0;
    tick();
    $display("press p%0d sel=%b acc=%0d rej=%0d count=%0d", p, s, acc, rej, move_count);
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  initial begin
    bit a, j;
    int accs, saved;
    reset = 1'b1; new_game = 1'b0; player_sel = '0; player_confirm = '0;
    new3 = 1'b0; sel3 = '0; conf3 = '0;
    m_prev = '0; m_acc = 1'b0; m_rej = 1'b0;
    model_clear();
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_count", move_count, 0);

    // First move lands at the bottom of column 3
    press(0, 7'b0001000, a, j);
    check("r021_acc", a, 1);
    check("r021_cell", tokens[5][3], 1);
    check("r021_cur", current_player, 1);
    check("r021_count", move_count, 1);
    check("r021_lr", last_row, 5);
    check("r021_lc", last_col, 3);

    // Column 0 alternates and overflows on the seventh attempt
    pulse_new_game();
    for (int k = 0; k < 6; k++) press(k % 2, 7'b0000001, a, j);
    for (int k = 0; k < 6; k++) check("r022_col", tokens[5-k][0], (k % 2) + 1);
    press(0, 7'b0000001, a, j);
    check("r022_rej", j, 1);
    check("r022_cur", current_player, 0);

    // Held confirm yields a single move; off-turn confirm is ignored
    pulse_new_game();
    accs = 0;
    player_sel[0] = 7'b0000100;
    player_confirm[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (move_accepted) accs++;
    end
    player_confirm[0] = 1'b0;
    tick();
    check("r023_hold", accs, 1);
    press(1, 7'b0000100, a, j);
    saved = move_count;
    player_sel[1] = 7'b0000010;
    player_confirm[1] = 1'b1;
    tick();
    check("r023_other_acc", move_accepted, 0);
    check("r023_other_rej", move_rejected, 0);
    check("r023_other_cnt", move_count, saved);
    player_confirm[1] = 1'b0;
    tick();

    // Malformed selects are refused
    press(0, 7'b0011000, a, j);
    check("r024_two_hot", j, 1);
    press(0, 7'b0000000, a, j);
    check("r024_none", j, 1);
    check("r024_cnt", move_count, saved);

    // Fill the board, then restart with confirm held across new_game
    pulse_new_game();
    for (int c = 0; c < C; c++)
      for (int k = 0; k < R; k++) press(m_cur, 7'(1 << c), a, j);
    check("r025_full", board_full, 1);
    check("r025_count", move_count, 42);
    press(m_cur, 7'b1000000, a, j);
    check("r025_rej_full", j, 1);
    player_sel[0] = 7'b0000001;
    player_confirm[0] = 1'b1;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    accs = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (move_accepted || move_rejected) accs++;
    end
    check("r025_held_pulses", accs, 0);
    check("r025_cleared", move_count, 0);
    check("r025_cur", current_player, 0);
    player_confirm[0] = 1'b0;
    tick();
    press(0, 7'b0000001, a, j);
    check("r025_repress", a, 1);

    // Three-player wraparound on the small board
    for (int k = 0; k < 3; k++) begin
      sel3[k] = 4'b0100;
      conf3[k] = 1'b1;
      tick();
      check("r026_acc", acc3, 1);
      conf3[k] = 1'b0;
      tick();
      if (k == 1) check("r026_cur2", cur3, 2);
      $display("p3 move p%0d count=%0d cur=%0d", k, cnt3, cur3);
    end
    check("r026_owner_b", tok3[3][2], 1);
    check("r026_owner_m", tok3[2][2], 2);
    check("r026_owner_t", tok3[1][2], 3);
    check("r026_empty", tok3[0][2], 0);
    check("r026_wrap", cur3, 0);
    check("r026_count", cnt3, 3);

    // Random play against the model
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 399) == 0);
      new_game = ($urandom_range(0, 249) == 0);
      player_confirm = P'($urandom);
      for (int p = 0; p < P; p++) begin
        case ($urandom_range(0, 9))
          0:       player_sel[p] = C'($urandom);
          1:       player_sel[p] = '0;
          default: player_sel[p] = C'(1 << $urandom_range(0, C - 1));
        endcase
      end
      tick();
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
